// File: rtl/hack_pkg.sv
// Shared types for the HACK memory arbiter: data word, arbiter state and
// the default video age limit.
package hack_pkg;

    localparam int AGE_LIMIT_DEF = 4;

    typedef logic [15:0] word_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CPU_RD = 2'd1,
        VID_RD = 2'd2
    } arb_state_t;

endpackage

// File: rtl/hack_mem_arbiter_if.sv
// Bus bundle between the CPU/video requesters, the arbiter and the
// single-port RAM. The arbiter connects as slave; the requester/RAM side
// (or a bench) connects as master.
interface hack_mem_arbiter_if;
    import hack_pkg::*;

    logic  cpu_req;
    logic  cpu_we;
    word_t cpu_addr;
    word_t cpu_wdata;
    logic  cpu_stall;
    logic  cpu_rvalid;
    word_t cpu_rdata;

    logic  vid_req;
    word_t vid_addr;
    logic  vid_gnt;
    logic  vid_rvalid;
    word_t vid_rdata;

    word_t ram_addr;
    logic  ram_we;
    word_t ram_wdata;
    word_t ram_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_stall, cpu_rvalid, cpu_rdata,
        input  vid_req, vid_addr,
        output vid_gnt, vid_rvalid, vid_rdata,
        output ram_addr, ram_we, ram_wdata,
        input  ram_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_stall, cpu_rvalid, cpu_rdata,
        output vid_req, vid_addr,
        input  vid_gnt, vid_rvalid, vid_rdata,
        input  ram_addr, ram_we, ram_wdata,
        output ram_rdata
    );

endinterface

// File: rtl/hack_arb_age_ctr.sv
// Video starvation guard: counts cycles the video requester has waited
// and flags it as aged once the wait reaches AGE_LIMIT. Saturates at
// AGE_LIMIT so it never wraps back to "young".
module hack_arb_age_ctr #(
    parameter int AGE_LIMIT = 4
) (
    input  logic clk,
    input  logic rstn,
    input  logic vid_req,
    input  logic vid_gnt,
    output logic aged
);

    localparam int W = (AGE_LIMIT < 1) ? 1 : $clog2(AGE_LIMIT + 1);
    localparam logic [W-1:0] LIMIT = W'(AGE_LIMIT);

    logic [W-1:0] cnt;

    // Wait counter: clear on grant, count up while waiting, hold at limit.
    always_ff @(posedge clk) begin
        if (!rstn)
            cnt <= '0;
        else if (vid_gnt)
            cnt <= '0;
        else if (vid_req && (cnt < LIMIT))
            cnt <= cnt + W'(1);
    end

    assign aged = (cnt >= LIMIT);

endmodule

// File: rtl/hack_mem_arbiter.sv
// Single-port RAM arbiter between the CPU data port and video scan-out.
// One access per cycle, one-cycle read latency, CPU priority by default.
// Optional feature macro HACK_ARB_AGE_EN: video wins a contest once it has
// waited AGE_LIMIT cycles (hack_arb_age_ctr).
module hack_mem_arbiter
    import hack_pkg::*;
#(
    parameter int AGE_LIMIT = AGE_LIMIT_DEF
) (
    input logic               clk,
    input logic               rstn,
    hack_mem_arbiter_if.slave bus
);

    arb_state_t state_q, state_d;
    logic       cpu_gnt;
    logic       vid_gnt;
    logic       aged;
    word_t      addr_q;
    word_t      wdata_q;

`ifdef HACK_ARB_AGE_EN
    hack_arb_age_ctr #(.AGE_LIMIT(AGE_LIMIT)) u_age (
        .clk     (clk),
        .rstn    (rstn),
        .vid_req (bus.vid_req),
        .vid_gnt (vid_gnt),
        .aged    (aged)
    );
`else
    // Strict CPU priority: video never ages (expression is constant false
    // for any legal AGE_LIMIT).
    assign aged = (AGE_LIMIT < 0);
`endif

    // State register; an in-flight read is dropped by reset.
    always_ff @(posedge clk) begin
        if (!rstn)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Arbitration, next state and all outputs; everything forced to 0 in reset.
    always_comb begin
        state_d        = IDLE;
        cpu_gnt        = 1'b0;
        vid_gnt        = 1'b0;
        bus.cpu_stall  = 1'b0;
        bus.cpu_rvalid = 1'b0;
        bus.cpu_rdata  = '0;
        bus.vid_gnt    = 1'b0;
        bus.vid_rvalid = 1'b0;
        bus.vid_rdata  = '0;
        bus.ram_addr   = '0;
        bus.ram_we     = 1'b0;
        bus.ram_wdata  = '0;
        if (rstn) begin
            // CPU sits out its own data-return cycle; video is always eligible.
            cpu_gnt = bus.cpu_req && (state_q != CPU_RD) && !(bus.vid_req && aged);
            vid_gnt = bus.vid_req && !cpu_gnt;

            if (cpu_gnt && !bus.cpu_we)
                state_d = CPU_RD;
            else if (vid_gnt)
                state_d = VID_RD;

            // In CPU_RD the CPU consumes rdata, so it is never stalled there.
            if (state_q != CPU_RD)
                bus.cpu_stall = (bus.cpu_req && !cpu_gnt) || (cpu_gnt && !bus.cpu_we);

            if (state_q == CPU_RD) begin
                bus.cpu_rvalid = 1'b1;
                bus.cpu_rdata  = bus.ram_rdata;
            end
            if (state_q == VID_RD) begin
                bus.vid_rvalid = 1'b1;
                bus.vid_rdata  = bus.ram_rdata;
            end

            bus.vid_gnt = vid_gnt;

            // Idle cycles keep the last address/data on the RAM bus.
            bus.ram_addr  = addr_q;
            bus.ram_wdata = wdata_q;
            if (cpu_gnt) begin
                bus.ram_addr  = bus.cpu_addr;
                bus.ram_we    = bus.cpu_we;
                bus.ram_wdata = bus.cpu_wdata;
            end else if (vid_gnt) begin
                bus.ram_addr  = bus.vid_addr;
            end
        end
    end

    // Remember the RAM bus so it can be held when nobody is granted.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            addr_q  <= bus.ram_addr;
            wdata_q <= bus.ram_wdata;
        end
    end

endmodule

// File: tb/tb_hack_mem_arbiter.sv
// Directed bench for hack_mem_arbiter: a vector table for single-cycle
// behaviour plus hand sequences for the aging contest and mid-read reset.
module tb_hack_mem_arbiter;

    logic clk = 1'b0;
    logic rstn;
    int   checks = 0;
    int   failures = 0;

    hack_mem_arbiter_if bus();

    hack_mem_arbiter #(.AGE_LIMIT(4)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Synchronous single-port RAM: read data one cycle after the address.
    logic [15:0] mem [0:65535];
    always @(posedge clk) begin
        if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
        bus.ram_rdata <= mem[bus.ram_addr];
    end

`ifdef HACK_ARB_AGE_EN
    localparam int EXP_C = 4;
`else
    localparam int EXP_C = 99;
`endif

    typedef struct {
        logic        rstn, cr, cw;
        logic [15:0] ca, cd;
        logic        vr;
        logic [15:0] va;
        logic        stall, crv;
        logic [15:0] crd;
        logic        vg, vrv;
        logic [15:0] vrd;
        logic        rwe;
        logic [15:0] raddr;
    } vec_t;

    vec_t tbl [15];

    function automatic vec_t mk(logic r, logic cr, logic cw, logic [15:0] ca, logic [15:0] cd,
                                logic vr, logic [15:0] va, logic st, logic crv, logic [15:0] crd,
                                logic vg, logic vrv, logic [15:0] vrd, logic rwe, logic [15:0] ra);
        vec_t v;
        v.rstn = r;  v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd; v.vr = vr; v.va = va;
        v.stall = st; v.crv = crv; v.crd = crd; v.vg = vg; v.vrv = vrv; v.vrd = vrd;
        v.rwe = rwe; v.raddr = ra;
        return v;
    endfunction

    task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One cycle: drive just after the rising edge, sample on the falling edge.
    task automatic drive(logic r, logic cr, logic cw, logic [15:0] ca, logic [15:0] cd,
                         logic vr, logic [15:0] va);
        @(posedge clk);
        #1;
        rstn = r; bus.cpu_req = cr; bus.cpu_we = cw; bus.cpu_addr = ca;
        bus.cpu_wdata = cd; bus.vid_req = vr; bus.vid_addr = va;
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
        mem[16'h4000] = 16'h1234;
        mem[16'h5000] = 16'hCAFE;
        rstn = 1'b0; bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0;
        bus.cpu_wdata = '0; bus.vid_req = 1'b0; bus.vid_addr = '0;

        //             rstn cr cw ca        cd        vr va         st crv crd       vg vrv vrd       we raddr
        tbl[0]  = mk(0, 1, 0, 16'h4000, 16'h0000, 1, 16'h5000, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000);
        tbl[1]  = mk(0, 1, 0, 16'h4000, 16'h0000, 1, 16'h5000, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000);
        tbl[2]  = mk(0, 1, 0, 16'h4000, 16'h0000, 1, 16'h5000, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000);
        tbl[3]  = mk(1, 1, 0, 16'h4000, 16'h0000, 1, 16'h5000, 1, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h4000);
        tbl[4]  = mk(1, 0, 0, 16'h0000, 16'h0000, 1, 16'h5000, 0, 1, 16'h1234, 1, 0, 16'h0000, 0, 16'h5000);
        tbl[5]  = mk(1, 1, 1, 16'h0010, 16'hBEEF, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 16'hCAFE, 1, 16'h0010);
        tbl[6]  = mk(1, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0010);
        tbl[7]  = mk(1, 1, 0, 16'h0010, 16'h0000, 0, 16'h0000, 1, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0010);
        tbl[8]  = mk(1, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 1, 16'hBEEF, 0, 0, 16'h0000, 0, 16'h0010);
        tbl[9]  = mk(1, 1, 0, 16'h4000, 16'h0000, 0, 16'h0000, 1, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h4000);
        tbl[10] = mk(1, 1, 0, 16'h4000, 16'h0000, 0, 16'h0000, 0, 1, 16'h1234, 0, 0, 16'h0000, 0, 16'h4000);
        tbl[11] = mk(1, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h4000);
        tbl[12] = mk(1, 1, 1, 16'h0020, 16'h1111, 1, 16'h5000, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0020);
        tbl[13] = mk(1, 0, 0, 16'h0000, 16'h0000, 1, 16'h5000, 0, 0, 16'h0000, 1, 0, 16'h0000, 0, 16'h5000);
        tbl[14] = mk(1, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 16'hCAFE, 0, 16'h5000);

        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].rstn, tbl[i].cr, tbl[i].cw, tbl[i].ca, tbl[i].cd, tbl[i].vr, tbl[i].va);
            chk($sformatf("v%0d cpu_stall", i),  16'(bus.cpu_stall),  16'(tbl[i].stall));
            chk($sformatf("v%0d cpu_rvalid", i), 16'(bus.cpu_rvalid), 16'(tbl[i].crv));
            chk($sformatf("v%0d cpu_rdata", i),  bus.cpu_rdata,       tbl[i].crd);
            chk($sformatf("v%0d vid_gnt", i),    16'(bus.vid_gnt),    16'(tbl[i].vg));
            chk($sformatf("v%0d vid_rvalid", i), 16'(bus.vid_rvalid), 16'(tbl[i].vrv));
            chk($sformatf("v%0d vid_rdata", i),  bus.vid_rdata,       tbl[i].vrd);
            chk($sformatf("v%0d ram_we", i),     16'(bus.ram_we),     16'(tbl[i].rwe));
            chk($sformatf("v%0d ram_addr", i),   bus.ram_addr,        tbl[i].raddr);
        end

        // Contest: CPU write stream against a waiting video read of 0x4000.
        // With aging, video wins on the 5th cycle; without, the CPU always wins.
        for (int c = 0; c < 6; c++) begin
            drive(1, 1, 1, 16'h0100 + 16'(c), 16'hA000 + 16'(c), (c <= EXP_C), 16'h4000);
            chk($sformatf("age c%0d vid_gnt", c),    16'(bus.vid_gnt),    16'(c == EXP_C));
            chk($sformatf("age c%0d cpu_stall", c),  16'(bus.cpu_stall),  16'(c == EXP_C));
            chk($sformatf("age c%0d ram_we", c),     16'(bus.ram_we),     16'(c != EXP_C));
            chk($sformatf("age c%0d ram_addr", c),   bus.ram_addr,
                (c == EXP_C) ? 16'h4000 : 16'h0100 + 16'(c));
            chk($sformatf("age c%0d vid_rvalid", c), 16'(bus.vid_rvalid), 16'(c == EXP_C + 1));
        end
        // Written data landed: write at 0x0100 happened in cycle 0 in both builds.
        chk("age write landed", mem[16'h0100], 16'hA000);

        // Video read grant, then reset in the data-return cycle.
        drive(1, 0, 0, 16'h0000, 16'h0000, 1, 16'h5000);
        chk("mrst grant vid_gnt", 16'(bus.vid_gnt), 16'd1);
        drive(0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000);
        chk("mrst in-reset vid_rvalid", 16'(bus.vid_rvalid), 16'd0);
        chk("mrst in-reset vid_rdata", bus.vid_rdata, 16'h0000);
        // First cycle after release arbitrates normally; stale read is gone.
        drive(1, 1, 0, 16'h4000, 16'h0000, 1, 16'h5000);
        chk("mrst post vid_rvalid", 16'(bus.vid_rvalid), 16'd0);
        chk("mrst post cpu_rvalid", 16'(bus.cpu_rvalid), 16'd0);
        chk("mrst post cpu_stall", 16'(bus.cpu_stall), 16'd1);
        chk("mrst post vid_gnt", 16'(bus.vid_gnt), 16'd0);
        chk("mrst post ram_addr", bus.ram_addr, 16'h4000);
        drive(1, 0, 0, 16'h0000, 16'h0000, 1, 16'h5000);
        chk("mrst rd cpu_rvalid", 16'(bus.cpu_rvalid), 16'd1);
        chk("mrst rd cpu_rdata", bus.cpu_rdata, 16'h1234);
        chk("mrst rd vid_gnt", 16'(bus.vid_gnt), 16'd1);
        drive(1, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000);
        chk("mrst rd vid_rvalid", 16'(bus.vid_rvalid), 16'd1);
        chk("mrst rd vid_rdata", bus.vid_rdata, 16'hCAFE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hack_mem_arbiter.md
HACK_MEM_ARBITER -- requirements
Module: hack_mem_arbiter

Interface
REQ-001 Parameter AGE_LIMIT, default 4: video-wait cycles after which video beats the CPU in a contest.
REQ-002 The block SHALL use one clock and a synchronous, active-low reset, with ports: clk  in  1  rising-edge clock.
REQ-003 The reset port SHALL be: rstn  in  1  synchronous active-low reset.
REQ-004 cpu_req  in  1  CPU data-memory access request.
REQ-005 cpu_we  in  1  CPU access is a write.
REQ-006 cpu_addr  in  16  CPU word address.
REQ-007 cpu_wdata  in  16  CPU write data.
REQ-008 cpu_stall  out  1  CPU clock-enable inhibit.
REQ-009 cpu_rvalid  out  1  CPU read data valid.
REQ-010 cpu_rdata  out  16  CPU read data.
REQ-011 vid_req  in  1  video scan-out read request.
REQ-012 vid_addr  in  16  video word address.
REQ-013 vid_gnt  out  1  video request accepted.
REQ-014 vid_rvalid  out  1  video read data valid.
REQ-015 vid_rdata  out  16  video read data.
REQ-016 ram_addr  out  16  single-port RAM address.
REQ-017 ram_we  out  1  RAM write strobe.
REQ-018 ram_wdata  out  16  RAM write data.
REQ-019 ram_rdata  in  16  RAM read data, one cycle after the address is presented.

Function
REQ-020 Each cycle, the block SHALL choose at most one eligible requester, using combinational logic, and drive that requester's address, write-enable and write data onto ram_* in the same cycle (the grant cycle).
REQ-021 States SHALL be IDLE, CPU_RD (CPU data-return cycle) and VID_RD (video data-return cycle); after a read grant to X the next state SHALL be X_RD; otherwise the next state SHALL be IDLE.
REQ-022 In CPU_RD the CPU SHALL be ineligible; cpu_rvalid=1; cpu_rdata=ram_rdata; the video requester remains eligible (back-to-back pipelining).
REQ-023 In VID_RD, vid_rvalid=1 and vid_rdata=ram_rdata; both requesters remain eligible.
REQ-024 Contest (both eligible): the CPU wins unless the video requester is aged (REQ-033); the loser's request is held, not dropped.
REQ-025 cpu_stall = (cpu_req & ~cpu_granted) | (cpu_granted & ~cpu_we); it SHALL be 0 in CPU_RD, which is the cycle in which the stalled CPU consumes cpu_rdata.
REQ-026 A CPU write SHALL complete in its grant cycle: no stall and no rvalid.
REQ-027 vid_gnt SHALL be asserted only in a video grant cycle; the requester holds vid_req and vid_addr stable until vid_gnt is asserted.
REQ-028 When no requester is granted, ram_we=0 and ram_addr/ram_wdata SHALL hold their previous values.
REQ-029 Read latency SHALL be exactly one cycle from grant to rvalid for both ports; throughput SHALL be one access per cycle.

Reset
REQ-030 While rstn=0 at a clock edge: state=IDLE, age counter=0, every output=0, ram_we=0.
REQ-031 A read in flight when reset is applied SHALL be discarded: no rvalid after reset.
REQ-032 The first cycle after rstn rises SHALL arbitrate normally.

Configuration
REQ-033 With HACK_ARB_AGE_EN defined, a saturating counter SHALL increment each cycle with vid_req=1 and vid_gnt=0, and clear on vid_gnt; when counter>=AGE_LIMIT, video SHALL win the next contest.
REQ-034 Without HACK_ARB_AGE_EN, the CPU SHALL have strict priority, no counter SHALL be built, and video may starve.

Structure
REQ-035 hack_pkg SHALL hold: word_t (16-bit), arb_state_t (IDLE/CPU_RD/VID_RD), default AGE_LIMIT.
REQ-036 The age counter SHALL be the sub-module hack_arb_age_ctr, instantiated only under HACK_ARB_AGE_EN.

Verification
REQ-037 Reset: rstn=0 for 3 cycles with cpu_req=vid_req=1 -> all outputs 0; first grant goes to the CPU on the cycle after release.
REQ-038 CPU read: cpu_req=1, we=0, addr=0x4000, RAM holds 0x1234 -> cpu_stall=1 in the grant cycle; next cycle cpu_rvalid=1, cpu_rdata=0x1234, stall=0.
REQ-039 CPU write: addr=0x0010, wdata=0xBEEF -> same cycle ram_we=1 and ram_addr=0x0010, no stall; a later read of 0x0010 returns 0xBEEF.
REQ-040 Contest: CPU write stream plus vid_req at addr 0x4000, AGE_LIMIT=4, HACK_ARB_AGE_EN defined -> vid_gnt on the 5th cycle, cpu_stall=1 in that cycle, counter cleared.
REQ-041 Pipelining: CPU read grant, then vid_req in CPU_RD -> vid_gnt in the same cycle as cpu_rvalid; vid_rvalid on the following cycle.
REQ-042 Mid-read reset: rstn=0 in the cycle after a video read grant -> vid_rvalid stays 0 and state=IDLE.
